// File: rtl/intercpu_sb_arbiter.sv
// -----------------------------------------------------------------------------
// intercpu_sb_arbiter
// Arbitrates four CPUs onto a shared B register file. One transaction is in
// flight at a time and walks IDLE -> EXEC -> ACK. The winner is picked
// round-robin. A per-cluster test-and-set lock can fence writes and unlocks
// from other CPUs.
//
// Ports
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_req[3:0]      per-CPU request level, CPU k on bit k
//   i_op[7:0]       per-CPU opcode, CPU k at [2k+1:2k]
//                   (00 read, 01 write, 10 lock, 11 unlock)
//   i_cln[11:0]     per-CPU cluster number, CPU k at [3k+2:3k]
//   i_j[11:0]       per-CPU register index, CPU k at [3k+2:3k]
//   i_wdata[95:0]   per-CPU write data, CPU k at [24k+23:24k]
//   o_ack[3:0]      one-hot completion strobe, high for the single ACK cycle
//   o_err           error flag, valid with o_ack
//   o_rdata[23:0]   read or lock result, valid with o_ack
//   o_sb_we         write strobe to storage, high only in EXEC
//   o_sb_cln/o_sb_j cluster and register select for the write port and read mux
//   o_sb_wdata      write data to storage
//   i_sb_rdata      read-mux output for the current o_sb_cln/o_sb_j
// -----------------------------------------------------------------------------
module intercpu_sb_arbiter #(
    parameter int NCLUSTER = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_req,
    input  logic [7:0]  i_op,
    input  logic [11:0] i_cln,
    input  logic [11:0] i_j,
    input  logic [95:0] i_wdata,
    output logic [3:0]  o_ack,
    output logic        o_err,
    output logic [23:0] o_rdata,
    output logic        o_sb_we,
    output logic [2:0]  o_sb_cln,
    output logic [2:0]  o_sb_j,
    output logic [23:0] o_sb_wdata,
    input  logic [23:0] i_sb_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_LOCK   = 2'b10;
    localparam logic [1:0] OP_UNLOCK = 2'b11;

    // Cluster numbers are 3 bits wide, so NCLUSTER is meaningful up to 7.
    localparam logic [3:0] NCL_W = 4'(NCLUSTER);

    // Round-robin pick starting at ptr; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    state_t          state_r;
    logic [1:0]      ptr_r;
    logic [7:0]      lock_r;
    logic [7:0][1:0] owner_r;

    // Transaction context captured when the winner is granted.
    logic [1:0]      win_r;
    logic [1:0]      op_r;
    logic [2:0]      cln_r;
    logic            err_r;
    logic            old_lock_r;

    logic [2:0]      pick_s;
    logic            any_s;
    logic [1:0]      win_s;
    logic [2:0]      op_base_s;
    logic [3:0]      sel_base_s;
    logic [6:0]      wd_base_s;
    logic [1:0]      sel_op_s;
    logic [2:0]      sel_cln_s;
    logic [2:0]      sel_j_s;
    logic [23:0]     sel_wdata_s;
    logic            cln_ok_s;
    logic            cur_lock_s;
    logic [1:0]      cur_owner_s;
    logic            err_s;

    // Winner selection and error classification for the candidate in IDLE.
    always_comb begin
        pick_s      = rr_pick(i_req, ptr_r);
        any_s       = pick_s[2];
        win_s       = pick_s[1:0];
        op_base_s   = {win_s, 1'b0};
        sel_base_s  = 4'(win_s) * 4'd3;
        wd_base_s   = 7'(win_s) * 7'd24;
        sel_op_s    = i_op[op_base_s +: 2];
        sel_cln_s   = i_cln[sel_base_s +: 3];
        sel_j_s     = i_j[sel_base_s +: 3];
        sel_wdata_s = i_wdata[wd_base_s +: 24];
        cln_ok_s    = (sel_cln_s != 3'd0) && ({1'b0, sel_cln_s} <= NCL_W);
        cur_lock_s  = lock_r[sel_cln_s];
        cur_owner_s = owner_r[sel_cln_s];
        case (sel_op_s)
            OP_WRITE:  err_s = !cln_ok_s || (cur_lock_s && (cur_owner_s != win_s));
            // An unlocked cluster has no owner, so unlocking it is an error.
            OP_UNLOCK: err_s = !cln_ok_s || !(cur_lock_s && (cur_owner_s == win_s));
            default:   err_s = !cln_ok_s;
        endcase
    end

    // Transaction FSM, lock table and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 2'd0;
            lock_r     <= 8'd0;
            owner_r    <= '0;
            win_r      <= 2'd0;
            op_r       <= 2'd0;
            cln_r      <= 3'd0;
            err_r      <= 1'b0;
            old_lock_r <= 1'b0;
            o_ack      <= 4'd0;
            o_err      <= 1'b0;
            o_rdata    <= 24'd0;
            o_sb_we    <= 1'b0;
            o_sb_cln   <= 3'd0;
            o_sb_j     <= 3'd0;
            o_sb_wdata <= 24'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_ack   <= 4'd0;
                    o_err   <= 1'b0;
                    o_rdata <= 24'd0;
                    if (any_s) begin
                        win_r      <= win_s;
                        op_r       <= sel_op_s;
                        cln_r      <= sel_cln_s;
                        err_r      <= err_s;
                        old_lock_r <= cur_lock_s;
                        o_sb_cln   <= sel_cln_s;
                        o_sb_j     <= sel_j_s;
                        o_sb_wdata <= sel_wdata_s;
                        // Raised here so the strobe coincides with EXEC.
                        o_sb_we    <= (sel_op_s == OP_WRITE) && !err_s;
                        state_r    <= ST_EXEC;
                    end else begin
                        o_sb_we <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    o_sb_we <= 1'b0;
                    o_ack   <= 4'b0001 << win_r;
                    o_err   <= err_r;
                    if (err_r) begin
                        o_rdata <= 24'd0;
                    end else begin
                        case (op_r)
                            OP_READ: o_rdata <= i_sb_rdata;
                            OP_LOCK: o_rdata <= {23'd0, old_lock_r};
                            default: o_rdata <= 24'd0;
                        endcase
                        if ((op_r == OP_LOCK) && !old_lock_r) begin
                            lock_r[cln_r]  <= 1'b1;
                            owner_r[cln_r] <= win_r;
                        end else if (op_r == OP_UNLOCK) begin
                            lock_r[cln_r]  <= 1'b0;
                            owner_r[cln_r] <= 2'd0;
                        end else begin
                            lock_r <= lock_r;
                        end
                    end
                    state_r <= ST_ACK;
                end
                ST_ACK: begin
                    o_ack   <= 4'd0;
                    o_err   <= 1'b0;
                    o_rdata <= 24'd0;
                    o_sb_we <= 1'b0;
                    ptr_r   <= win_r + 2'd1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    o_ack   <= 4'd0;
                    o_err   <= 1'b0;
                    o_rdata <= 24'd0;
                    o_sb_we <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
